// File: rtl/hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_unit                                                          |
// | Pipeline forwarding, load-use/branch stall-flush control, long-      |
// | multiply Execute occupancy FSM and saturating stall/flush counters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_unit #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  Ra1D,
   input  logic [3:0]  Ra2D,
   input  logic [3:0]  Ra1E,
   input  logic [3:0]  Ra2E,
   input  logic [3:0]  WA3E,
   input  logic [3:0]  WA3M,
   input  logic [3:0]  WA3W,
   input  logic [3:0]  WA2M,
   input  logic [3:0]  WA2W,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        RegWrite2M,
   input  logic        RegWrite2W,
   input  logic        MemToRegE,
   input  logic        PCSrcD,
   input  logic        PCSrcE,
   input  logic        PCSrcM,
   input  logic        PCSrcW,
   input  logic        BranchTakenE,
   input  logic        MulStartE,
   input  logic        ClrCount,
   output logic [2:0]  ForwardAE,
   output logic [2:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic        MulBusy,
   output logic [15:0] StallCount,
   output logic [15:0] FlushCount
);

   localparam int c_CNT_W = ($clog2(MUL_CYCLES) + 1 > 4) ? $clog2(MUL_CYCLES) + 1 : 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_nextCnt;
   logic                 w_hold;
   logic                 w_ldStall;
   logic                 w_pcPend;
   logic                 w_mulGo;
   logic [15:0]          r_stallCount;
   logic [15:0]          r_flushCount;

   // Newest producer wins; register 15 is the PC and is never forwarded.
   function automatic logic [2:0] fwdSel(
      input logic [3:0] ra,
      input logic       wM,  input logic [3:0] aM,
      input logic       w2M, input logic [3:0] a2M,
      input logic       wW,  input logic [3:0] aW,
      input logic       w2W, input logic [3:0] a2W
   );
      logic [2:0] sel;
      sel = 3'b000;
      if (ra != 4'hF) begin
         if (wM && aM == ra)        sel = 3'b010;
         else if (w2M && a2M == ra) sel = 3'b011;
         else if (wW && aW == ra)   sel = 3'b001;
         else if (w2W && a2W == ra) sel = 3'b100;
      end
      return sel;
   endfunction

   assign ForwardAE = fwdSel(Ra1E, RegWriteM, WA3M, RegWrite2M, WA2M,
                             RegWriteW, WA3W, RegWrite2W, WA2W);
   assign ForwardBE = fwdSel(Ra2E, RegWriteM, WA3M, RegWrite2M, WA2M,
                             RegWriteW, WA3W, RegWrite2W, WA2W);

   assign w_ldStall = MemToRegE && ((Ra1D == WA3E) || (Ra2D == WA3E));
   assign w_pcPend  = PCSrcD || PCSrcE || PCSrcM;
   assign w_mulGo   = MulStartE && !BranchTakenE && !PCSrcM && !PCSrcW;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // Hold covers every occupancy cycle except the last, so the multiply
   // sits in Execute for exactly MUL_CYCLES cycles.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_hold      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mulGo) begin
               w_nextState = BUSY;
               w_nextCnt   = c_CNT_W'(MUL_CYCLES - 1);
               w_hold      = 1'b1;
            end
         end
         BUSY: begin
            w_nextCnt = r_cnt - 1'b1;
            if (r_cnt == c_CNT_W'(1)) w_nextState = IDLE;
            else                      w_hold      = 1'b1;
         end
         default: w_nextState = IDLE;
      endcase
      if (!reset) w_hold = 1'b0;
   end

   always_comb begin
      StallF = w_ldStall || w_pcPend;
      StallD = w_ldStall;
      StallE = 1'b0;
      FlushD = w_pcPend || PCSrcW || BranchTakenE;
      FlushE = w_ldStall || BranchTakenE;
      FlushM = 1'b0;
      if (w_hold) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
         FlushM = 1'b1;
      end
   end

   assign MulBusy = (r_state == BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stallCount <= '0;
         r_flushCount <= '0;
      end else if (ClrCount) begin
         r_stallCount <= '0;
         r_flushCount <= '0;
      end else begin
         if (StallD && r_stallCount != 16'hFFFF)
            r_stallCount <= r_stallCount + 16'd1;
         if ((FlushD || FlushE) && r_flushCount != 16'hFFFF)
            r_flushCount <= r_flushCount + 16'd1;
      end
   end

   assign StallCount = r_stallCount;
   assign FlushCount = r_flushCount;

endmodule
`default_nettype wire
